// File: rtl/uart_tx_if.sv
// Host-side handshake and serial-line signals of the UART transmitter.
// master = the host that writes bytes, slave = the transmitter.
interface uart_tx_if;
  logic       en_tx;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       parity_en;
  logic       parity_odd;
  logic       stop2;
  logic       txd;
  logic       tx_full;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output en_tx, tx_data, tx_wr, parity_en, parity_odd, stop2,
    input  txd, tx_full, tx_busy, tx_done
  );

  modport slave (
    input  en_tx, tx_data, tx_wr, parity_en, parity_odd, stop2,
    output txd, tx_full, tx_busy, tx_done
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: one holding register feeding a shift register, 8 data bits LSB first,
// optional parity and one or two stop bits; each bit lasts OVERSAMPLE en_tx ticks.
module uart_tx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus
);
  localparam int TW = $clog2(OVERSAMPLE);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state_reg, state_next;
  logic [7:0]    hold_reg, hold_next;
  logic          full_reg, full_next;
  logic [7:0]    shift_reg, shift_next;
  logic [TW-1:0] tick_reg, tick_next;
  logic [2:0]    bit_reg, bit_next;
  logic          stop_cnt_reg, stop_cnt_next;
  logic          par_en_reg, par_en_next;
  logic          par_bit_reg, par_bit_next;
  logic          stop2_reg, stop2_next;
  logic          txd_reg, txd_next;
  logic          done_reg, done_next;
  logic          bit_end;
  logic          load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      hold_reg     <= '0;
      full_reg     <= 1'b0;
      shift_reg    <= '0;
      tick_reg     <= '0;
      bit_reg      <= '0;
      stop_cnt_reg <= 1'b0;
      par_en_reg   <= 1'b0;
      par_bit_reg  <= 1'b0;
      stop2_reg    <= 1'b0;
      txd_reg      <= 1'b1;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      hold_reg     <= hold_next;
      full_reg     <= full_next;
      shift_reg    <= shift_next;
      tick_reg     <= tick_next;
      bit_reg      <= bit_next;
      stop_cnt_reg <= stop_cnt_next;
      par_en_reg   <= par_en_next;
      par_bit_reg  <= par_bit_next;
      stop2_reg    <= stop2_next;
      txd_reg      <= txd_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    hold_next     = hold_reg;
    full_next     = full_reg;
    shift_next    = shift_reg;
    tick_next     = tick_reg;
    bit_next      = bit_reg;
    stop_cnt_next = stop_cnt_reg;
    par_en_next   = par_en_reg;
    par_bit_next  = par_bit_reg;
    stop2_next    = stop2_reg;
    txd_next      = txd_reg;
    done_next     = 1'b0;
    load          = 1'b0;
    bit_end       = bus.en_tx && (tick_reg == TW'(OVERSAMPLE - 1));

    if (state_reg != IDLE && bus.en_tx)
      tick_next = bit_end ? '0 : tick_reg + TW'(1);

    case (state_reg)
      IDLE: begin
        if (full_reg)
          load = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
          txd_next   = shift_reg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_next = shift_reg >> 1;
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'd7) begin
            state_next = par_en_reg ? PARITY : STOP;
            txd_next   = par_en_reg ? par_bit_reg : 1'b1;
          end else begin
            txd_next = shift_reg[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_next = STOP;
          txd_next   = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop2_reg && !stop_cnt_reg) begin
            stop_cnt_next = 1'b1;
          end else begin
            done_next = 1'b1;
            if (full_reg) begin
              load = 1'b1;
            end else begin
              state_next = IDLE;
              txd_next   = 1'b1;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Frame start; parity is folded into one bit now since the shift register is consumed.
    if (load) begin
      state_next    = START;
      shift_next    = hold_reg;
      full_next     = 1'b0;
      tick_next     = '0;
      bit_next      = '0;
      stop_cnt_next = 1'b0;
      par_en_next   = bus.parity_en;
      par_bit_next  = (^hold_reg) ^ bus.parity_odd;
      stop2_next    = bus.stop2;
      txd_next      = 1'b0;
    end

    // A write lands whenever the holding register is empty or is emptying this cycle.
    if (bus.tx_wr && (!full_reg || load)) begin
      hold_next = bus.tx_data;
      full_next = 1'b1;
    end
  end

  assign bus.txd     = txd_reg;
  assign bus.tx_full = full_reg;
  assign bus.tx_busy = (state_reg != IDLE);
  assign bus.tx_done = done_reg;
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed frames on an OVERSAMPLE=16 instance and random traffic on an
// OVERSAMPLE=4 instance, decoded by a tick-counting line monitor against a scoreboard.
module tb_uart_tx;
  localparam int OS16 = 16;
  localparam int OS4  = 4;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       po;
    logic       s2;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  uart_tx_if bus ();
  uart_tx_if bus4 ();

  uart_tx #(.OVERSAMPLE(OS16)) dut  (.clk(clk), .rst(rst), .bus(bus));
  uart_tx #(.OVERSAMPLE(OS4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

  assign bus4.en_tx      = bus.en_tx;
  assign bus4.tx_data    = bus.tx_data;
  assign bus4.tx_wr      = bus.tx_wr;
  assign bus4.parity_en  = bus.parity_en;
  assign bus4.parity_odd = bus.parity_odd;
  assign bus4.stop2      = bus.stop2;

  always #5 clk = ~clk;

  int          errors    = 0;
  int          checks    = 0;
  int          en_mode   = 0;
  int          done_cnt  = 0;
  int          frame_cnt = 0;
  logic        use4      = 1'b0;
  logic [11:0] last_bits = '0;
  exp_t        sb[$];

  logic mon_txd, mon_busy, mon_full, mon_done;
  assign mon_txd  = use4 ? bus4.txd     : bus.txd;
  assign mon_busy = use4 ? bus4.tx_busy : bus.tx_busy;
  assign mon_full = use4 ? bus4.tx_full : bus.tx_full;
  assign mon_done = use4 ? bus4.tx_done : bus.tx_done;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    return 1'b1;
  endfunction

  task automatic en_gen();
    int cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      case (en_mode)
        1: begin
          cnt = (cnt + 1) % 4;
          bus.en_tx = (cnt == 0);
        end
        2: bus.en_tx = 1'($urandom_range(0, 1));
        default: bus.en_tx = 1'b1;
      endcase
    end
  endtask

  task automatic done_mon();
    forever begin
      @(negedge clk);
      if (mon_done === 1'b1) done_cnt++;
    end
  endtask

  // Counts en_tx ticks from the start edge and samples each bit in the middle of its period.
  task automatic decoder();
    logic        active = 1'b0;
    int          c = 0;
    int          nb = 10;
    int          os = OS16;
    logic [11:0] bits;
    logic [11:0] ev;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        active = 1'b0;
        continue;
      end
      if (!active && mon_txd == 1'b0) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_frame", 32'(sb.size()), 32'd1);
          e = '0;
        end else begin
          e = sb[0];
        end
        active = 1'b1;
        c      = 0;
        nb     = 10 + int'(e.pe) + int'(e.s2);
        os     = use4 ? OS4 : OS16;
        bits   = '0;
      end
      if (active && bus.en_tx) begin
        if (c % os == os / 2) bits[c/os] = mon_txd;
        if (c == (nb - 1) * os + os / 2) begin
          ev = '0;
          ev[8:1] = e.d;
          for (int k = 9; k < 12; k++) if (k < nb) ev[k] = 1'b1;
          if (e.pe) ev[9] = (^e.d) ^ e.po;
          check_eq("frame", 32'(bits), 32'(ev));
          $display("frame %0d: data=%02h pe=%0d po=%0d s2=%0d line=%03h model=%03h",
                   frame_cnt, e.d, e.pe, e.po, e.s2, bits, ev);
          last_bits = bits;
          frame_cnt++;
          if (sb.size() != 0) void'(sb.pop_front());
          active = 1'b0;
        end
        c++;
      end
    end
  endtask

  // Called at posedge+1; the write is taken on the next edge and returns at that edge+1.
  task automatic send(input logic [7:0] d, input logic pe, input logic po, input logic s2);
    exp_t e;
    bus.tx_data    = d;
    bus.parity_en  = pe;
    bus.parity_odd = po;
    bus.stop2      = s2;
    bus.tx_wr      = 1'b1;
    @(posedge clk);
    #1;
    bus.tx_wr = 1'b0;
    e = '{d: d, pe: pe, po: po, s2: s2};
    sb.push_back(e);
  endtask

  task automatic wait_idle(input string tag, output int n);
    n = 0;
    while (n < 5000) begin
      @(posedge clk);
      #1;
      n++;
      if (!mon_busy && !mon_full) break;
    end
    if (n >= 5000) check_eq({tag, "_timeout"}, 32'(n), 32'd0);
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int d0;
    int f0;
    int k;
    int t;
    int tr[12];
    logic prev;

    bus.en_tx      = 1'b1;
    bus.tx_wr      = 1'b0;
    bus.tx_data    = '0;
    bus.parity_en  = 1'b0;
    bus.parity_odd = 1'b0;
    bus.stop2      = 1'b0;
    rst            = 1'b1;
    fork
      en_gen();
      done_mon();
      decoder();
      begin
        #1500000;
        $display("FAIL watchdog: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_txd", 32'(bus.txd), 32'd1);
    check_eq("rst_full", 32'(bus.tx_full), 32'd0);
    check_eq("rst_busy", 32'(bus.tx_busy), 32'd0);
    check_eq("rst_done", 32'(bus.tx_done), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 0x55, no parity, one stop bit: every clk of the 160-clk frame
    d0 = done_cnt;
    send(8'h55, 1'b0, 1'b0, 1'b0);
    check_eq("full_after_write", 32'(bus.tx_full), 32'd1);
    for (int i = 0; i < 160; i++) begin
      @(posedge clk);
      #1;
      check_eq("txd_55", 32'(bus.txd), 32'(frame_bit(8'h55, i / 16)));
    end
    check_eq("busy_55_end", 32'(bus.tx_busy), 32'd1);
    @(posedge clk);
    #1;
    check_eq("busy_55_after", 32'(bus.tx_busy), 32'd0);
    check_eq("txd_55_idle", 32'(bus.txd), 32'd1);
    settle();
    check_eq("done_55", 32'(done_cnt - d0), 32'd1);

    // 0xA3 with even then odd parity: 11-bit frames
    d0 = done_cnt;
    send(8'hA3, 1'b1, 1'b0, 1'b0);
    wait_idle("a3_even", n);
    check_eq("len_a3_even", 32'(n), 32'd177);
    settle();
    check_eq("par_a3_even", 32'(last_bits[9]), 32'd0);
    send(8'hA3, 1'b1, 1'b1, 1'b0);
    wait_idle("a3_odd", n);
    check_eq("len_a3_odd", 32'(n), 32'd177);
    settle();
    check_eq("par_a3_odd", 32'(last_bits[9]), 32'd1);
    check_eq("done_a3", 32'(done_cnt - d0), 32'd2);

    // 0x01 then 0xFF on consecutive clks, a third write dropped; frames back-to-back
    d0 = done_cnt;
    bus.tx_data   = 8'h01;
    bus.parity_en = 1'b0;
    bus.stop2     = 1'b1;
    bus.tx_wr     = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('{d: 8'h01, pe: 1'b0, po: bus.parity_odd, s2: 1'b1});
    check_eq("b2b_full_1", 32'(bus.tx_full), 32'd1);
    bus.tx_data = 8'hFF;
    @(posedge clk);
    #1;
    sb.push_back('{d: 8'hFF, pe: 1'b0, po: bus.parity_odd, s2: 1'b1});
    check_eq("b2b_full_2", 32'(bus.tx_full), 32'd1);
    bus.tx_data = 8'h77;
    @(posedge clk);
    #1;
    bus.tx_wr = 1'b0;
    check_eq("b2b_full_3", 32'(bus.tx_full), 32'd1);
    wait_idle("b2b", n);
    check_eq("len_b2b", 32'(n), 32'd351);
    settle();
    check_eq("done_b2b", 32'(done_cnt - d0), 32'd2);
    check_eq("sb_b2b", 32'(sb.size()), 32'd0);
    bus.stop2 = 1'b0;

    // en_tx on every 4th clk: each data bit spans 64 clk
    en_mode = 1;
    send(8'h55, 1'b0, 1'b0, 1'b0);
    k    = 0;
    t    = 0;
    prev = bus.txd;
    while (t < 3000) begin
      @(posedge clk);
      #1;
      t++;
      if (bus.txd !== prev) begin
        if (k < 12) tr[k] = t;
        k++;
        prev = bus.txd;
      end
      if (!bus.tx_busy && !bus.tx_full) break;
    end
    check_eq("slow_edges", 32'(k), 32'd10);
    for (int i = 1; i < 9; i++) check_eq("slow_bit_len", 32'(tr[i+1] - tr[i]), 32'd64);
    en_mode = 0;
    settle();

    // reset in mid-DATA with a byte waiting
    bus.tx_data = 8'h3C;
    bus.tx_wr   = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('{d: 8'h3C, pe: 1'b0, po: bus.parity_odd, s2: 1'b0});
    bus.tx_data = 8'hC3;
    @(posedge clk);
    #1;
    bus.tx_wr = 1'b0;
    sb.push_back('{d: 8'hC3, pe: 1'b0, po: bus.parity_odd, s2: 1'b0});
    check_eq("pre_rst_full", 32'(bus.tx_full), 32'd1);
    repeat (60) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("abort_txd", 32'(bus.txd), 32'd1);
    check_eq("abort_full", 32'(bus.tx_full), 32'd0);
    check_eq("abort_busy", 32'(bus.tx_busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    sb.delete();
    rst = 1'b0;
    @(posedge clk);
    #1;
    d0 = done_cnt;
    send(8'h96, 1'b0, 1'b0, 1'b0);
    wait_idle("post_rst", n);
    check_eq("len_post_rst", 32'(n), 32'd161);
    settle();
    check_eq("done_post_rst", 32'(done_cnt - d0), 32'd1);
    check_eq("sb_post_rst", 32'(sb.size()), 32'd0);

    // 1000 random bytes and configurations on the fast instance, written as soon as it has room
    settle();
    use4 = 1'b1;
    f0   = frame_cnt;
    for (int i = 0; i < 1000; i++) begin
      en_mode = (i < 100) ? 2 : 0;
      n = 0;
      while (bus4.tx_full && n < 2000) begin
        @(posedge clk);
        #1;
        n++;
      end
      if (n >= 2000) check_eq("rnd_full_timeout", 32'(n), 32'd0);
      send(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    en_mode = 0;
    wait_idle("rnd", n);
    settle();
    check_eq("rnd_frames", 32'(frame_cnt - f0), 32'd1000);
    check_eq("rnd_sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter OVERSAMPLE, default 16: en_tx ticks per bit period; legal range 2..256.
REQ-002 clk  input  1  UART clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 en_tx  input  1  bit-rate tick, one clk wide, from the baud divisor; may be held high continuously.
REQ-005 tx_data  input  8  byte to send; sampled only on a cycle where tx_wr=1 and tx_full=0.
REQ-006 tx_wr  input  1  write strobe.
REQ-007 parity_en  input  1  1 = append parity bit; sampled when a frame starts.
REQ-008 parity_odd  input  1  1 = odd parity, 0 = even; sampled when a frame starts.
REQ-009 stop2  input  1  1 = two stop bits, 0 = one; sampled when a frame starts.
REQ-010 txd  output  1  serial line, registered, idle high.
REQ-011 tx_full  output  1  holding register occupied; writes are ignored while high.
REQ-012 tx_busy  output  1  a frame is on the line (state not IDLE).
REQ-013 tx_done  output  1  one-clk pulse after the last stop bit completes.

Function
REQ-014 Buffering: one 8-bit holding register plus one shift register; one byte can wait while another shifts.
REQ-015 An accepted write sets tx_full on the next clk edge; tx_wr while tx_full=1 shall be dropped silently, with no state change.
REQ-016 States: IDLE, START, DATA, PARITY, STOP.
REQ-017 IDLE with tx_full=1: on the next clk edge, load shift register from holding register, clear tx_full, latch parity_en/parity_odd/stop2, clear tick and bit counters, enter START, drive txd=0.
REQ-018 Bit period: tick counter increments on each clk with en_tx=1; a bit ends on the clk where the counter equals OVERSAMPLE-1 and en_tx=1; the counter then wraps to 0.
REQ-019 START end -> DATA, txd = shift[0] (LSB first).
REQ-020 DATA: at each bit end, shift right, increment bit counter; after the 8th data bit -> PARITY if the latched parity_en=1, else STOP.
REQ-021 PARITY: txd = XOR of the 8 data bits XOR parity_odd; at bit end -> STOP.
REQ-022 STOP: txd=1 for 1 bit period, or 2 periods if the latched stop2=1; at the end, pulse tx_done for one clk.
REQ-023 STOP end with tx_full=1: the next frame's start bit begins on that same edge (back-to-back, no idle gap), with tx_done still pulsed; otherwise -> IDLE.
REQ-024 A write on the same clk where the holding register empties into the shift register shall be accepted; tx_full stays 1.
REQ-025 en_tx low: all counters hold, txd holds, and the state does not advance; tx_wr acceptance is independent of en_tx.
REQ-026 Frame length in bits: 10 + parity_en + stop2; each bit lasts exactly OVERSAMPLE en_tx ticks.
REQ-027 Changes on parity_en/parity_odd/stop2 in mid-frame shall not affect the current frame.

Reset
REQ-028 rst=1 forces state=IDLE, txd=1, tx_full=0, tx_busy=0, tx_done=0, and all counters and registers to 0, asynchronously.
REQ-029 rst during a frame aborts it; txd returns high immediately and the held byte is discarded.
REQ-030 First frame after rst deasserts: the first tx_wr is accepted; no spurious tx_done.

Verification
REQ-031 OVERSAMPLE=16, en_tx=1 always, write 0x55, no parity, 1 stop -> txd: 0, then 1,0,1,0,1,0,1,0, then 1, each held 16 clk; one tx_done; tx_busy low after 160 clk.
REQ-032 Write 0xA3, parity_en=1, parity_odd=0 -> parity bit 0 (four ones); parity_odd=1 -> parity bit 1; frame is 11 bits.
REQ-033 Write 0x01 then 0xFF immediately, stop2=1 -> second write accepted, third write while tx_full=1 dropped; frames are contiguous with no idle bit between them; two tx_done pulses.
REQ-034 en_tx every 4th clk -> each bit lasts 64 clk; txd stable between ticks.
REQ-035 rst asserted mid-DATA with tx_full=1 -> txd=1, tx_full=0, tx_busy=0 within the same cycle; a new write after release sends a clean frame.
REQ-036 Bench checks a serial decoder against scoreboard for 1000 random bytes and configs: zero mismatches.
